// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: shared ROM geometry and arbiter defaults
package rom_port_arbiter_pkg;
  localparam int ROM_DEPTH    = 256;
  localparam int DATA_WIDTH   = 32;
  localparam int ARB_MAX_WAIT = 4;
endpackage

// File: rtl/rom_rsp_slot.sv
// rom_rsp_slot: one-entry registered response buffer with valid/ready drain
module rom_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);
  // load overwrites the slot even while draining; data is held otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (load) rsp_data <= din;
      rsp_valid <= load | (rsp_valid & ~rsp_ready);
    end
  end
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one ROM read port between fetch (I) and load (D)
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = $clog2(ROM_DEPTH),
  parameter int DATA_W   = DATA_WIDTH,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              i_rsp_ready,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  input  logic              d_rsp_ready,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              rom_en_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic          elig_i, elig_d, grant_i, grant_d, force_i;
  logic [CW-1:0] wait_cnt;
  // D wins ties unless I has been denied MAX_WAIT cycles in a row
  always_comb begin
    elig_i     = i_req_valid && (!i_rsp_valid || i_rsp_ready);
    elig_d     = d_req_valid && (!d_rsp_valid || d_rsp_ready);
    force_i    = wait_cnt == CW'(MAX_WAIT);
    grant_d    = elig_d && !(elig_i && force_i);
    grant_i    = elig_i && !grant_d;
    rom_addr_o = grant_d ? d_req_addr : i_req_addr;
    rom_en_o   = grant_i | grant_d;
  end
  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  // counts consecutive cycles I is eligible but denied, saturating
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wait_cnt <= '0;
    else wait_cnt <= (grant_i || !elig_i) ? '0 : force_i ? wait_cnt : wait_cnt + 1'b1;
  end
  rom_rsp_slot #(.DATA_W(DATA_W)) u_i_slot (
    .clk       (clk),
    .rstn      (rstn),
    .load      (grant_i),
    .din       (rom_data_i),
    .rsp_ready (i_rsp_ready),
    .rsp_valid (i_rsp_valid),
    .rsp_data  (i_rsp_data)
  );
  rom_rsp_slot #(.DATA_W(DATA_W)) u_d_slot (
    .clk       (clk),
    .rstn      (rstn),
    .load      (grant_d),
    .din       (rom_data_i),
    .rsp_ready (d_rsp_ready),
    .rsp_valid (d_rsp_valid),
    .rsp_data  (d_rsp_data)
  );
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed checks of arbitration, slots and reset
module tb_rom_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
  logic          d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [AW-1:0] i_req_addr, d_req_addr, rom_addr_o;
  logic [DW-1:0] i_rsp_data, d_rsp_data, rom_data_i;
  logic          rom_en_o;
  int            n_tests = 0;
  int            n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction
  assign rom_data_i = rom_f(rom_addr_o);
  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .i_req_ready (i_req_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .i_rsp_ready (i_rsp_ready),
    .d_req_valid (d_req_valid),
    .d_req_addr  (d_req_addr),
    .d_req_ready (d_req_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .d_rsp_ready (d_rsp_ready),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .rom_en_o    (rom_en_o)
  );
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic iv, input logic [AW-1:0] ia, input logic ir,
                       input logic dv, input logic [AW-1:0] da, input logic dr);
    i_req_valid = iv;
    i_req_addr  = ia;
    i_rsp_ready = ir;
    d_req_valid = dv;
    d_req_addr  = da;
    d_rsp_ready = dr;
    #1;
  endtask
  task automatic both_pattern(input int n, input logic [AW-1:0] base);
    logic exp_i;
    for (int c = 0; c < n; c++) begin
      exp_i = (c % 5) == 4;
      drive(1'b1, base + AW'(c), 1'b1, 1'b1, base + 8'h10 + AW'(c), 1'b1);
      chk($sformatf("pat_i_rdy%0d", c), DW'(i_req_ready), DW'(exp_i));
      chk($sformatf("pat_d_rdy%0d", c), DW'(d_req_ready), DW'(!exp_i));
      step();
      if (exp_i) chk($sformatf("pat_i_data%0d", c), i_rsp_data, rom_f(base + AW'(c)));
      else chk($sformatf("pat_d_data%0d", c), d_rsp_data, rom_f(base + 8'h10 + AW'(c)));
    end
  endtask
  initial begin
    rstn = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    step();
    chk("rst_i_valid", DW'(i_rsp_valid), 0);
    chk("rst_d_valid", DW'(d_rsp_valid), 0);
    chk("rst_i_data", i_rsp_data, 0);
    chk("rst_d_data", d_rsp_data, 0);
    chk("rst_en", DW'(rom_en_o), 0);
    chk("rst_rdy", DW'({i_req_ready, d_req_ready}), 0);
    rstn = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, AW'(k), 1'b1, 1'b0, '0, 1'b1);
      chk($sformatf("ionly_rdy%0d", k), DW'(i_req_ready), 1);
      chk($sformatf("ionly_addr%0d", k), DW'(rom_addr_o), DW'(k));
      step();
      chk($sformatf("ionly_valid%0d", k), DW'(i_rsp_valid), 1);
      chk($sformatf("ionly_data%0d", k), i_rsp_data, rom_f(AW'(k)));
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    step();
    both_pattern(10, 8'h20);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b1, 8'h10, 1'b0);
    chk("bp_d_rdy0", DW'(d_req_ready), 1);
    step();
    chk("bp_d_data0", d_rsp_data, rom_f(8'h10));
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h40 + AW'(k), 1'b1, 1'b1, 8'h11, 1'b0);
      chk($sformatf("bp_d_blocked%0d", k), DW'(d_req_ready), 0);
      chk($sformatf("bp_i_rdy%0d", k), DW'(i_req_ready), 1);
      step();
      chk($sformatf("bp_d_hold%0d", k), d_rsp_data, rom_f(8'h10));
      chk($sformatf("bp_d_valid%0d", k), DW'(d_rsp_valid), 1);
      chk($sformatf("bp_i_data%0d", k), i_rsp_data, rom_f(8'h40 + AW'(k)));
    end
    drive(1'b0, '0, 1'b1, 1'b1, 8'h11, 1'b1);
    chk("reload_rdy", DW'(d_req_ready), 1);
    chk("reload_addr", DW'(rom_addr_o), 32'h11);
    step();
    chk("reload_valid", DW'(d_rsp_valid), 1);
    chk("reload_data", d_rsp_data, rom_f(8'h11));
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h50, 1'b1, 1'b1, 8'h60 + AW'(k), 1'b1);
      chk($sformatf("pre_rst_d%0d", k), DW'(d_req_ready), 1);
      step();
    end
    chk("pre_rst_dvalid", DW'(d_rsp_valid), 1);
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    rstn = 1'b0;
    #1;
    chk("async_d_valid", DW'(d_rsp_valid), 0);
    chk("async_d_data", d_rsp_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    drive(1'b1, 8'h07, 1'b1, 1'b0, '0, 1'b1);
    chk("post_rst_i_rdy", DW'(i_req_ready), 1);
    step();
    chk("post_rst_i_data", i_rsp_data, rom_f(8'h07));
    drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    step();
    both_pattern(5, 8'h80);
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("idle_en", DW'(rom_en_o), 0);
    chk("idle_rdy", DW'({i_req_ready, d_req_ready}), 0);
    step();
    chk("idle_i_valid", DW'(i_rsp_valid), 1);
    chk("idle_d_valid", DW'(d_rsp_valid), 0);
    chk("idle_i_data", i_rsp_data, rom_f(8'h84));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
